// File: rtl/wb_ram_if.sv
// Wishbone bus bundle shared by the processor and its memory slaves.
interface WISHBONE_IF (
    input logic iClk,
    input logic nRst
);
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  width;
    logic [31:0] data_write;
    logic [31:0] data_read;
    logic        ack;

    modport slave (
        input  iClk, nRst, cyc, stb, we, addr, width, data_write,
        output data_read, ack
    );

    modport master (
        input  iClk, nRst, data_read, ack,
        output cyc, stb, we, addr, width, data_write
    );
endinterface

// File: rtl/wb_ram.sv
// Word-organised Wishbone RAM slave with registered reads, optional wait states and misalign flagging.
// Define RAM_RESET_CLEAR_EN to zero the whole array after every reset release.
module wb_ram #(
    parameter int SIZE        = 4096,
    parameter int WAIT_STATES = 0
) (
    WISHBONE_IF.slave mem_wb,
    output logic      oBusy,
    output logic      oMisalign
);
    localparam int AW    = $clog2(SIZE);
    localparam int IW    = AW - 2;
    localparam int WORDS = SIZE / 4;
    localparam logic [1:0]    CNT_LOAD  = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;
    localparam logic [IW-1:0] LAST_WORD = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ACK   = 2'd2
`ifdef RAM_RESET_CLEAR_EN
        , CLEAR = 2'd3
`endif
    } state_t;

    state_t        state, nxt;
    logic [1:0]    cnt, cnt_nxt;
    logic          req;
    logic [AW-1:0] lat_addr;
    logic [1:0]    lat_width;
    logic          lat_we;
    logic [31:0]   lat_wdata;
    logic [AW-1:0] sel_addr;
    logic [1:0]    sel_width;
    logic          sel_we;
    logic [31:0]   sel_wdata;
    logic [IW-1:0] widx;
    logic [1:0]    lane;
    logic          mis;
    logic          enter_ack;
    logic          wr_en;
    logic [3:0]    be;
    logic [31:0]   wlane;
    logic [31:0]   rd_word;
    logic [31:0]   rd_val;
    logic [31:0]   mem [WORDS];
    logic          unused_addr_hi;
`ifdef RAM_RESET_CLEAR_EN
    logic [IW-1:0] clr_idx;
`endif

    assign req            = mem_wb.cyc & mem_wb.stb;
    assign unused_addr_hi = ^mem_wb.addr[31:AW];

    // In IDLE the request is taken straight off the bus so zero-wait accesses complete on the sampling edge.
    assign sel_addr  = (state == IDLE) ? mem_wb.addr[AW-1:0] : lat_addr;
    assign sel_width = (state == IDLE) ? mem_wb.width        : lat_width;
    assign sel_we    = (state == IDLE) ? mem_wb.we           : lat_we;
    assign sel_wdata = (state == IDLE) ? mem_wb.data_write   : lat_wdata;
    assign widx      = sel_addr[AW-1:2];
    assign lane      = sel_addr[1:0];
    assign mis       = ((sel_width == 2'b01) && lane[0]) || (sel_width[1] && (lane != 2'b00));
    assign enter_ack = (nxt == ACK) && (state != ACK);
    assign wr_en     = enter_ack && sel_we && !mis && mem_wb.nRst;

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    if (WAIT_STATES > 0) begin
                        nxt     = WAIT;
                        cnt_nxt = CNT_LOAD;
                    end else begin
                        nxt = ACK;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    nxt     = IDLE;
                    cnt_nxt = 2'd0;
                end else if (cnt == 2'd0) begin
                    nxt = ACK;
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
            ACK: nxt = IDLE;
`ifdef RAM_RESET_CLEAR_EN
            CLEAR: if (clr_idx == LAST_WORD) nxt = IDLE;
`endif
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        be    = 4'b1111;
        wlane = sel_wdata;
        case (sel_width)
            2'b00: begin
                be    = 4'b0001 << lane;
                wlane = {4{sel_wdata[7:0]}};
            end
            2'b01: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wlane = {2{sel_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign rd_word = mem[widx];

    always_comb begin
        rd_val = rd_word;
        case (sel_width)
            2'b00:   rd_val = {24'd0, rd_word[{lane, 3'b000} +: 8]};
            2'b01:   rd_val = lane[1] ? {16'd0, rd_word[31:16]} : {16'd0, rd_word[15:0]};
            default: ;
        endcase
    end

    // Array has no reset so it maps onto block RAM; the clear engine rewrites it word by word.
    always_ff @(posedge mem_wb.iClk) begin
`ifdef RAM_RESET_CLEAR_EN
        if (state == CLEAR) begin
            mem[clr_idx] <= '0;
        end else
`endif
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[widx][8*b +: 8] <= wlane[8*b +: 8];
            end
        end
    end

    always_ff @(posedge mem_wb.iClk) begin
        if (state == IDLE && req) begin
            lat_addr  <= mem_wb.addr[AW-1:0];
            lat_width <= mem_wb.width;
            lat_we    <= mem_wb.we;
            lat_wdata <= mem_wb.data_write;
        end
    end

    always_ff @(posedge mem_wb.iClk or negedge mem_wb.nRst) begin
        if (!mem_wb.nRst) begin
`ifdef RAM_RESET_CLEAR_EN
            state   <= CLEAR;
            clr_idx <= '0;
`else
            state   <= IDLE;
`endif
            cnt              <= 2'd0;
            mem_wb.ack       <= 1'b0;
            mem_wb.data_read <= '0;
            oMisalign        <= 1'b0;
        end else begin
            state            <= nxt;
            cnt              <= cnt_nxt;
            mem_wb.ack       <= enter_ack;
            mem_wb.data_read <= (enter_ack && !mis) ? rd_val : 32'd0;
            oMisalign        <= enter_ack && mis;
`ifdef RAM_RESET_CLEAR_EN
            if (state == CLEAR) clr_idx <= clr_idx + IW'(1);
`endif
        end
    end

`ifdef RAM_RESET_CLEAR_EN
    assign oBusy = (state == CLEAR);
`else
    assign oBusy = 1'b0;
`endif
endmodule

// File: tb/tb_wb_ram.sv
// Directed bench for wb_ram: zero-wait instance (4 KiB) and two-wait instance (256 B) on one clock.
module tb_wb_ram;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    WISHBONE_IF bus0 (.iClk(clk), .nRst(rst_n));
    WISHBONE_IF bus2 (.iClk(clk), .nRst(rst_n));
    logic busy0, mis0, busy2, mis2;

    wb_ram #(.SIZE(4096), .WAIT_STATES(0)) dut0 (.mem_wb(bus0), .oBusy(busy0), .oMisalign(mis0));
    wb_ram #(.SIZE(256),  .WAIT_STATES(2)) dut2 (.mem_wb(bus2), .oBusy(busy2), .oMisalign(mis2));

`ifdef RAM_RESET_CLEAR_EN
    localparam logic BUSY_RST = 1'b1;
`else
    localparam logic BUSY_RST = 1'b0;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] rd;
    logic        mis;
    int          lat;

    task automatic wb0_xfer(input logic w_en, input logic [1:0] w, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] r, output logic m, output int l);
        @(negedge clk);
        bus0.cyc = 1'b1; bus0.stb = 1'b1; bus0.we = w_en;
        bus0.width = w; bus0.addr = a; bus0.data_write = d;
        l = 99; r = 32'hx; m = 1'bx;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus0.ack) begin
                l = i; r = bus0.data_read; m = mis0;
                break;
            end
        end
        bus0.cyc = 1'b0; bus0.stb = 1'b0; bus0.we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wb2_xfer(input logic w_en, input logic [1:0] w, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] r, output logic m, output int l);
        @(negedge clk);
        bus2.cyc = 1'b1; bus2.stb = 1'b1; bus2.we = w_en;
        bus2.width = w; bus2.addr = a; bus2.data_write = d;
        l = 99; r = 32'hx; m = 1'bx;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus2.ack) begin
                l = i; r = bus2.data_read; m = mis2;
                break;
            end
        end
        bus2.cyc = 1'b0; bus2.stb = 1'b0; bus2.we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        int n;
        bus0.cyc = 0; bus0.stb = 0; bus0.we = 0; bus0.addr = 0; bus0.width = 0; bus0.data_write = 0;
        bus2.cyc = 0; bus2.stb = 0; bus2.we = 0; bus2.addr = 0; bus2.width = 0; bus2.data_write = 0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus0.ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", bus0.ack); end
        n_checks++; if (bus0.data_read !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", bus0.data_read); end
        n_checks++; if (mis0 !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b expected 0", mis0); end
        n_checks++; if (busy0 !== BUSY_RST) begin n_fail++; $display("FAIL reset_busy0: got %b expected %b", busy0, BUSY_RST); end
        n_checks++; if (busy2 !== BUSY_RST) begin n_fail++; $display("FAIL reset_busy2: got %b expected %b", busy2, BUSY_RST); end
        @(negedge clk); rst_n = 1'b1;
        n = 0;
        while ((busy0 || busy2) && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        n_checks++; if (busy0 !== 1'b0 || busy2 !== 1'b0) begin n_fail++; $display("FAIL busy_release: got %b/%b expected 0/0", busy0, busy2); end
    endtask

    task automatic test_word_rw;
        wb0_xfer(1'b1, 2'b10, 32'h10, 32'hDEADBEEF, rd, mis, lat);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL ws0_write_latency: got %0d expected 1", lat); end
        wb0_xfer(1'b0, 2'b10, 32'h10, 32'h0, rd, mis, lat);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL ws0_read_latency: got %0d expected 1", lat); end
        n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_read: got %h expected deadbeef", rd); end
        n_checks++; if (bus0.ack !== 1'b0 || bus0.data_read !== 32'd0) begin
            n_fail++; $display("FAIL ack_one_cycle: got ack %b data %h expected 0/0", bus0.ack, bus0.data_read);
        end
    endtask

    task automatic test_lanes;
        wb0_xfer(1'b1, 2'b10, 32'h20, 32'h11223344, rd, mis, lat);
        wb0_xfer(1'b1, 2'b00, 32'h22, 32'h000000AA, rd, mis, lat);
        wb0_xfer(1'b0, 2'b01, 32'h22, 32'h0, rd, mis, lat);
        n_checks++; if (rd !== 32'h000011AA) begin n_fail++; $display("FAIL half_read_22: got %h expected 000011aa", rd); end
        wb0_xfer(1'b0, 2'b00, 32'h23, 32'h0, rd, mis, lat);
        n_checks++; if (rd !== 32'h00000011) begin n_fail++; $display("FAIL byte_read_23: got %h expected 00000011", rd); end
        n_checks++; if (mis !== 1'b0) begin n_fail++; $display("FAIL byte_odd_aligned: got %b expected 0", mis); end
        wb0_xfer(1'b0, 2'b00, 32'h20, 32'h0, rd, mis, lat);
        n_checks++; if (rd !== 32'h00000044) begin n_fail++; $display("FAIL byte_read_20: got %h expected 00000044", rd); end
        wb0_xfer(1'b1, 2'b01, 32'h20, 32'hFFFF5566, rd, mis, lat);
        wb0_xfer(1'b0, 2'b11, 32'h20, 32'h0, rd, mis, lat);
        n_checks++; if (rd !== 32'h11AA5566) begin n_fail++; $display("FAIL half_write_20: got %h expected 11aa5566", rd); end
    endtask

    task automatic test_misalign;
        wb0_xfer(1'b1, 2'b01, 32'h21, 32'h0000FFFF, rd, mis, lat);
        n_checks++; if (lat !== 1 || mis !== 1'b1 || rd !== 32'd0) begin
            n_fail++; $display("FAIL misalign_half_write: got lat %0d mis %b data %h expected 1/1/0", lat, mis, rd);
        end
        wb0_xfer(1'b0, 2'b10, 32'h22, 32'h0, rd, mis, lat);
        n_checks++; if (lat !== 1 || mis !== 1'b1 || rd !== 32'd0) begin
            n_fail++; $display("FAIL misalign_word_read: got lat %0d mis %b data %h expected 1/1/0", lat, mis, rd);
        end
        n_checks++; if (mis0 !== 1'b0) begin n_fail++; $display("FAIL misalign_pulse: got %b expected 0", mis0); end
        wb0_xfer(1'b0, 2'b10, 32'h20, 32'h0, rd, mis, lat);
        n_checks++; if (rd !== 32'h11AA5566 || mis !== 1'b0) begin
            n_fail++; $display("FAIL misalign_no_write: got %h mis %b expected 11aa5566/0", rd, mis);
        end
    endtask

    task automatic test_wrap;
        wb0_xfer(1'b1, 2'b10, 32'h1004, 32'h55AA55AA, rd, mis, lat);
        wb0_xfer(1'b0, 2'b10, 32'h0004, 32'h0, rd, mis, lat);
        n_checks++; if (rd !== 32'h55AA55AA) begin n_fail++; $display("FAIL wrap: got %h expected 55aa55aa", rd); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        bus0.cyc = 1'b1; bus0.stb = 1'b1; bus0.we = 1'b1;
        bus0.width = 2'b10; bus0.addr = 32'h30; bus0.data_write = 32'hA5A50001;
        @(posedge clk); #1;
        n_checks++; if (bus0.ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack1: got %b expected 1", bus0.ack); end
        bus0.we = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (bus0.ack !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got %b expected 0", bus0.ack); end
        @(posedge clk); #1;
        n_checks++; if (bus0.ack !== 1'b1 || bus0.data_read !== 32'hA5A50001) begin
            n_fail++; $display("FAIL b2b_raw: got ack %b data %h expected 1/a5a50001", bus0.ack, bus0.data_read);
        end
        bus0.cyc = 1'b0; bus0.stb = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (bus0.ack !== 1'b0 || bus0.data_read !== 32'd0) begin
            n_fail++; $display("FAIL b2b_idle: got ack %b data %h expected 0/0", bus0.ack, bus0.data_read);
        end
    endtask

    task automatic test_wait_states;
        logic seen;
        wb2_xfer(1'b1, 2'b10, 32'h40, 32'hCAFEF00D, rd, mis, lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL ws2_write_latency: got %0d expected 3", lat); end
        wb2_xfer(1'b0, 2'b10, 32'h40, 32'h0, rd, mis, lat);
        n_checks++; if (lat !== 3 || rd !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL ws2_read: got lat %0d data %h expected 3/cafef00d", lat, rd);
        end
        @(negedge clk);
        bus2.cyc = 1'b1; bus2.stb = 1'b1; bus2.we = 1'b1;
        bus2.width = 2'b10; bus2.addr = 32'h40; bus2.data_write = 32'h12345678;
        @(posedge clk); #1;
        bus2.stb = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus2.ack) seen = 1'b1;
        end
        bus2.cyc = 1'b0; bus2.we = 1'b0;
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_ack: got %b expected 0", seen); end
        wb2_xfer(1'b0, 2'b10, 32'h40, 32'h0, rd, mis, lat);
        n_checks++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL abort_no_write: got %h expected cafef00d", rd); end
    endtask

`ifndef RAM_RESET_CLEAR_EN
    task automatic test_reset_mid;
        wb2_xfer(1'b1, 2'b10, 32'h50, 32'h01020304, rd, mis, lat);
        @(negedge clk);
        bus0.cyc = 1'b1; bus0.stb = 1'b1; bus0.we = 1'b0; bus0.width = 2'b10; bus0.addr = 32'h10;
        bus2.cyc = 1'b1; bus2.stb = 1'b1; bus2.we = 1'b1; bus2.width = 2'b10; bus2.addr = 32'h50;
        bus2.data_write = 32'h0BADF00D;
        @(posedge clk); #1;
        n_checks++; if (bus0.ack !== 1'b1) begin n_fail++; $display("FAIL pre_reset_ack: got %b expected 1", bus0.ack); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus0.ack !== 1'b0 || bus0.data_read !== 32'd0 || bus2.ack !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got ack0 %b data0 %h ack2 %b expected 0/0/0", bus0.ack, bus0.data_read, bus2.ack);
        end
        bus0.cyc = 0; bus0.stb = 0; bus2.cyc = 0; bus2.stb = 0; bus2.we = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        wb2_xfer(1'b0, 2'b10, 32'h50, 32'h0, rd, mis, lat);
        n_checks++; if (rd !== 32'h01020304) begin n_fail++; $display("FAIL reset_mid_no_write: got %h expected 01020304", rd); end
        wb0_xfer(1'b0, 2'b10, 32'h10, 32'h0, rd, mis, lat);
        n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL contents_survive_reset: got %h expected deadbeef", rd); end
    endtask
`else
    task automatic test_clear;
        int   n;
        logic seen;
        @(negedge clk);
        bus0.cyc = 1'b1; bus0.stb = 1'b1; bus0.we = 1'b0; bus0.width = 2'b10; bus0.addr = 32'h10;
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy0 !== 1'b1 || bus0.ack !== 1'b0) begin
            n_fail++; $display("FAIL clear_reset: got busy %b ack %b expected 1/0", busy0, bus0.ack);
        end
        @(negedge clk); rst_n = 1'b1;
        n = 0; seen = 1'b0;
        while (busy0 && n < 3000) begin
            @(posedge clk); #1; n++;
            if (bus0.ack) seen = 1'b1;
        end
        n_checks++; if (n !== 1024) begin n_fail++; $display("FAIL clear_cycles: got %0d expected 1024", n); end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL clear_ack_held: got %b expected 0", seen); end
        @(posedge clk); #1;
        n_checks++; if (bus0.ack !== 1'b1 || bus0.data_read !== 32'd0) begin
            n_fail++; $display("FAIL clear_read: got ack %b data %h expected 1/0", bus0.ack, bus0.data_read);
        end
        bus0.cyc = 1'b0; bus0.stb = 1'b0;
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_word_rw();
        test_lanes();
        test_misalign();
        test_wrap();
        test_back_to_back();
        test_wait_states();
`ifndef RAM_RESET_CLEAR_EN
        test_reset_mid();
`else
        test_clear();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/wb_ram.md
# wb_ram

Parametrised, word-organised on-chip RAM slave on the processor's Wishbone bus, replacing the single-cycle combinational byte-array RAM. Reads are registered with a configurable number of wait states so the array maps to FPGA block RAM. Misaligned accesses are detected and flagged. An optional post-reset clear engine zeroes the array.

## Interface
Parameters:
- SIZE, 4096, capacity in bytes; power of two, ≥ 8; stored as SIZE/4 32-bit words with four byte lanes
- WAIT_STATES, 0, extra cycles (0–3) inserted between request sample and ack

Ports:
- mem_wb.iClk  in  1  single clock; all state on rising edge
- mem_wb.nRst  in  1  asynchronous, active-low reset
- mem_wb  slave  WISHBONE_IF  bus port; uses cyc, stb, we, addr[31:0], width[1:0], data_write[31:0], data_read[31:0], ack
- oBusy  out  1  high while the clear engine runs; 0 when RAM_RESET_CLEAR_EN is absent
- oMisalign  out  1  one-cycle pulse, coincident with ack, for a misaligned access

## Operation
- Effective address: addr[log2(SIZE)-1:0]; upper bits ignored, so addresses wrap modulo SIZE. Word index = eff[log2(SIZE)-1:2]; lane = eff[1:0].
- width: 00 byte, 01 halfword, 10/11 word. Little-endian.
- Alignment: byte always aligned; halfword needs eff[0]=0; word needs eff[1:0]=00. Misaligned: write suppressed, data_read=0, still acked, oMisalign pulses.
- Write: byte lands in lane eff[1:0] from data_write[7:0]; halfword data_write[15:0] into lanes eff[1]*2+{0,1}; word writes all lanes. Other lanes untouched.
- Read: selected byte/halfword right-justified and zero-extended into data_read; word returned whole.
- States: CLEAR (macro only), IDLE, WAIT, ACK.
  - IDLE: on cyc&stb, latch addr/width/we/data_write; go WAIT if WAIT_STATES>0 (counter loaded with WAIT_STATES-1) else ACK.
  - WAIT: decrement; at 0 go ACK. If cyc or stb low at any WAIT edge, abort to IDLE: no write, no ack.
  - ACK: ack=1 for exactly one cycle; array write and data_read register update happen on the edge entering ACK. Next state IDLE.
- data_read is 0 whenever ack is 0.

## Timing
- Reset values: ack=0, data_read=0, oMisalign=0, oBusy=1 with macro else 0; state CLEAR with macro else IDLE; counter 0.
- Latency: request sampled at edge T; ack high during cycle T+1+WAIT_STATES.
- Throughput: one access per 2+WAIT_STATES cycles; stb held high after ack starts a new access on the IDLE edge.
- Reset mid-access: transaction discarded, no write, ack low immediately (asynchronous).
- Array contents survive reset unless RAM_RESET_CLEAR_EN is defined.
- Read-after-write to same address in consecutive transactions returns new data.

## Configuration
- RAM_RESET_CLEAR_EN defined: after nRst release, CLEAR writes zero to word 0..SIZE/4-1, one word per cycle (SIZE/4 cycles), oBusy=1, ack held 0. Requests during CLEAR stay pending and are sampled in the first IDLE cycle. Then IDLE, oBusy=0.
- Undefined: no CLEAR state, array never reset (pure BRAM inference), oBusy tied 0, first request accepted the first edge after reset release.

## Test plan
- WAIT_STATES=0: word write 0xDEADBEEF @0x10, then word read @0x10 -> ack one cycle after each sample, data_read=0xDEADBEEF.
- Byte/half lanes: word 0x11223344 @0x20; byte write 0xAA @0x22; half read @0x22 -> 0x000011AA; byte read @0x23 -> 0x00000011.
- Misalign: half write @0x21 and word read @0x22 -> ack with data_read=0, oMisalign pulses, memory @0x20 unchanged.
- WAIT_STATES=2: read ack exactly 3 cycles after sample; drop stb in WAIT during a write -> no ack, target word unchanged.
- Wrap: SIZE=4096, word write 0x55AA55AA @0x1004 -> word read @0x4 returns 0x55AA55AA.
- RAM_RESET_CLEAR_EN: preload nonzero, pulse nRst, hold a read request -> oBusy high 1024 cycles, then ack with data_read=0.
